// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Entry layout pairs a fetched word with its word-address PC.
package cpu_fetch_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 30;

    localparam logic [INST_W-1:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO with registered head output and synchronous clear.
// The head register always mirrors the oldest stored entry.
module fetch_fifo
    import cpu_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  fetch_entry_t     din,
    output fetch_entry_t     head,
    output logic             head_valid,
    output logic [PTR_W:0]   count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_nxt;
    logic [PTR_W:0]   count_nxt;
    logic             pop_ok;

    assign pop_ok    = pop & head_valid;
    assign rd_nxt    = rd_ptr + PTR_W'(1);
    assign count_nxt = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop_ok);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            if (rst) begin
                head <= '0;
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_nxt;
            end
            count <= count_nxt;
            if (count_nxt == '0) begin
                head_valid <= 1'b0;
            end else begin
                head_valid <= 1'b1;
                // New word becomes head when the queue is (or is about to be) empty
                if (count == '0 || (count == (PTR_W+1)'(1) && pop_ok)) begin
                    head <= din;
                end else if (pop_ok) begin
                    head <= mem[rd_nxt];
                end
            end
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Sequential instruction prefetcher: bus request FSM, fetch PC and queue.
// A flush turns an outstanding request into one whose response is dropped.
module inst_fetch_queue
    import cpu_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [29:0] RESET_PC = 30'h0,
    localparam int         PTR_W    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        flush,
    input  logic [29:0] flush_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [29:0] inst_pc,
    output logic        imr_run,
    output logic        i_read_req,
    output logic        i_read_w,
    output logic        i_read_hw,
    output logic [31:0] i_read_adr,
    input  logic        i_read_valid,
    input  logic [31:0] i_read_data
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] req_pc;
    logic [PTR_W:0]  count;
    logic            full;
    logic            push;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    assign full       = (count == FULL_CNT);
    assign i_read_req = (state == IDLE) & fetch_en & ~flush & ~full;
    assign i_read_w   = 1'b1;
    assign i_read_hw  = 1'b0;
    assign i_read_adr = {fetch_pc, 2'b00};
    assign imr_run    = i_read_req | (state != IDLE);

    assign push       = (state == WAIT) & i_read_valid & ~flush;
    assign pop        = inst_valid & inst_ready & ~flush;
    assign push_entry = '{pc: req_pc, inst: i_read_data};

    assign inst    = head.inst;
    assign inst_pc = head.pc;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (i_read_req) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (i_read_valid) begin
                    state_nxt = IDLE;
                end else if (flush) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (i_read_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else begin
            state <= state_nxt;
            if (i_read_req) begin
                req_pc <= fetch_pc;
            end
            if (flush) begin
                fetch_pc <= flush_pc;
            end else if (i_read_req) begin
                fetch_pc <= fetch_pc + PC_W'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush),
        .push       (push),
        .pop        (pop),
        .din        (push_entry),
        .head       (head),
        .head_valid (inst_valid),
        .count      (count)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: transaction-level model plus directed scenarios.
// Random phase at the end exercises flush/reset/stall interleavings.
module tb_inst_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [29:0] RPC   = 30'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        flush = 1'b0;
    logic [29:0] flush_pc = '0;
    logic        inst_ready = 1'b0;
    logic        i_read_valid = 1'b0;
    logic [31:0] i_read_data = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [29:0] inst_pc;
    logic        imr_run;
    logic        i_read_req;
    logic        i_read_w;
    logic        i_read_hw;
    logic [31:0] i_read_adr;

    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_en     (fetch_en),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .imr_run      (imr_run),
        .i_read_req   (i_read_req),
        .i_read_w     (i_read_w),
        .i_read_hw    (i_read_hw),
        .i_read_adr   (i_read_adr),
        .i_read_valid (i_read_valid),
        .i_read_data  (i_read_data)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: queue of {pc,data}, one pending request with a keep flag
    logic [61:0] mq [$];
    bit          m_pend = 0;
    bit          m_keep = 0;
    logic [29:0] m_ppc = '0;
    logic [29:0] m_fpc = '0;
    logic [29:0] req_log [$];
    logic [29:0] pop_log [$];
    bit          auto_resp = 0;
    bit          rnd_mode = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit m_req();
        return !m_pend && fetch_en && !flush && (mq.size() < DEPTH);
    endfunction

    task automatic model_update();
        bit          req;
        bit          popping;
        logic [61:0] e;
        if (rst) begin
            mq.delete();
            m_pend = 0;
            m_keep = 0;
            m_fpc  = RPC;
        end else begin
            req     = m_req();
            popping = (mq.size() > 0) && inst_ready && !flush;
            if (req) req_log.push_back(m_fpc);
            if (flush) begin
                mq.delete();
            end else begin
                if (popping) begin
                    e = mq.pop_front();
                    pop_log.push_back(e[61:32]);
                end
                if (m_pend && m_keep && i_read_valid)
                    mq.push_back({m_ppc, i_read_data});
            end
            if (m_pend && i_read_valid) m_pend = 0;
            else if (m_pend && flush) m_keep = 0;
            if (req) begin
                m_pend = 1;
                m_keep = 1;
                m_ppc  = m_fpc;
            end
            if (flush) m_fpc = flush_pc;
            else if (req) m_fpc = m_fpc + 30'd1;
        end
    endtask

    task automatic check_all();
        logic [61:0] e;
        chk("req", 32'(i_read_req), 32'(m_req()));
        chk("adr", i_read_adr, {m_fpc, 2'b00});
        chk("imr_run", 32'(imr_run), 32'(m_req() | m_pend));
        chk("valid", 32'(inst_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            e = mq[0];
            chk("inst", inst, e[31:0]);
            chk("inst_pc", 32'(inst_pc), 32'(e[61:32]));
        end
        chk("rw_hw", 32'({i_read_hw, i_read_w}), 32'd1);
    endtask

    task automatic cyc(input bit r, input bit fe, input bit fl,
                       input logic [29:0] fp, input bit rdy,
                       input bit rv, input logic [31:0] rd);
        @(posedge clk);
        model_update();
        #1;
        if (rnd_mode) begin
            r   = ($urandom_range(199) == 0);
            fe  = ($urandom_range(9) < 8);
            fl  = ($urandom_range(19) == 0);
            fp  = 30'($urandom);
            rdy = ($urandom_range(9) < 6);
            rv  = m_pend ? ($urandom_range(1) == 1) : ($urandom_range(19) == 0);
            rd  = $urandom;
        end else if (auto_resp && m_pend) begin
            rv = 1;
            rd = {2'b10, m_ppc};
        end
        rst          = r;
        fetch_en     = fe;
        flush        = fl;
        flush_pc     = fp;
        inst_ready   = rdy;
        i_read_valid = rv;
        i_read_data  = rd;
        #1;
        check_all();
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, '0, 0, 0, '0);
        cyc(0, 0, 0, '0, 0, 0, '0);
        req_log.delete();
        pop_log.delete();
    endtask

    initial begin
        cyc(1, 0, 0, '0, 0, 0, '0);
        cyc(1, 0, 0, '0, 0, 0, '0);
        cyc(0, 0, 0, '0, 0, 0, '0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc", 32'(inst_pc), 32'd0);
        chk("rst_req", 32'(i_read_req), 32'd0);
        chk("rst_run", 32'(imr_run), 32'd0);
        chk("rst_adr", i_read_adr, 32'h400);

        // Sequential fetch with a one-cycle bus
        req_log.delete();
        pop_log.delete();
        auto_resp = 1;
        repeat (12) cyc(0, 1, 0, '0, 1, 0, '0);
        chk("t1_reqs", 32'(req_log.size() >= 3), 32'd1);
        chk("t1_pops", 32'(pop_log.size() >= 3), 32'd1);
        for (int i = 0; i < 3 && i < req_log.size(); i++)
            chk("t1_req_pc", 32'(req_log[i]), 32'h100 + 32'(i));
        for (int i = 0; i < pop_log.size(); i++)
            chk("t1_pop_pc", 32'(pop_log[i]), 32'h100 + 32'(i));

        // Fill to DEPTH with decode stalled, then drain
        do_reset();
        repeat (20) cyc(0, 1, 0, '0, 0, 0, '0);
        chk("t2_reqs_full", 32'(req_log.size()), 32'd4);
        chk("t2_req_held", 32'(i_read_req), 32'd0);
        repeat (14) cyc(0, 1, 0, '0, 1, 0, '0);
        chk("t2_pops", 32'(pop_log.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < pop_log.size(); i++)
            chk("t2_pop_pc", 32'(pop_log[i]), 32'h100 + 32'(i));
        chk("t2_resume", 32'(req_log.size() >= 5), 32'd1);
        if (req_log.size() >= 5)
            chk("t2_resume_pc", 32'(req_log[4]), 32'h104);

        // Flush while WAIT, late response dropped
        auto_resp = 0;
        do_reset();
        cyc(0, 1, 0, '0, 0, 0, '0);
        cyc(0, 0, 1, 30'h200, 0, 0, '0);
        cyc(0, 0, 0, '0, 0, 1, 32'hDEADBEEF);
        cyc(0, 1, 0, '0, 0, 0, '0);
        chk("t3_req", 32'(i_read_req), 32'd1);
        chk("t3_adr", i_read_adr, 32'h800);
        chk("t3_empty", 32'(inst_valid), 32'd0);
        auto_resp = 1;
        repeat (6) cyc(0, 1, 0, '0, 1, 0, '0);
        chk("t3_pops", 32'(pop_log.size() >= 1), 32'd1);
        if (pop_log.size() >= 1)
            chk("t3_first_pc", 32'(pop_log[0]), 32'h200);

        // Flush coinciding with response
        auto_resp = 0;
        do_reset();
        cyc(0, 1, 0, '0, 0, 0, '0);
        cyc(0, 0, 1, 30'h300, 0, 1, 32'h12345678);
        cyc(0, 0, 0, '0, 0, 0, '0);
        chk("t4_run", 32'(imr_run), 32'd0);
        chk("t4_valid", 32'(inst_valid), 32'd0);
        cyc(0, 1, 0, '0, 0, 0, '0);
        chk("t4_req", 32'(i_read_req), 32'd1);
        chk("t4_adr", i_read_adr, 32'hC00);

        // Reset while WAIT with two queued entries
        do_reset();
        cyc(0, 1, 0, '0, 0, 0, '0);
        cyc(0, 0, 0, '0, 0, 1, 32'hA0000001);
        cyc(0, 1, 0, '0, 0, 0, '0);
        cyc(0, 0, 0, '0, 0, 1, 32'hA0000002);
        cyc(0, 1, 0, '0, 0, 0, '0);
        cyc(1, 0, 0, '0, 0, 0, '0);
        chk("t5_pre_cnt", 32'(mq.size()), 32'd2);
        chk("t5_pre_run", 32'(imr_run), 32'd1);
        cyc(0, 0, 0, '0, 0, 0, '0);
        chk("t5_valid", 32'(inst_valid), 32'd0);
        chk("t5_adr", i_read_adr, 32'h400);
        chk("t5_run", 32'(imr_run), 32'd0);
        cyc(0, 0, 0, '0, 0, 1, 32'hA0000003);
        cyc(0, 0, 0, '0, 0, 0, '0);
        chk("t5_late", 32'(inst_valid), 32'd0);

        // Push and pop together at count 1, then spurious response
        do_reset();
        cyc(0, 1, 0, '0, 0, 0, '0);
        cyc(0, 0, 0, '0, 0, 1, 32'h11110100);
        cyc(0, 1, 0, '0, 0, 0, '0);
        cyc(0, 0, 0, '0, 1, 1, 32'h22220101);
        chk("t6_head0", 32'(inst_pc), 32'h100);
        chk("t6_valid0", 32'(inst_valid), 32'd1);
        cyc(0, 0, 0, '0, 0, 0, '0);
        chk("t6_valid1", 32'(inst_valid), 32'd1);
        chk("t6_pc1", 32'(inst_pc), 32'h101);
        chk("t6_inst1", inst, 32'h22220101);
        cyc(0, 0, 0, '0, 0, 1, 32'h0BAD0BAD);
        cyc(0, 0, 0, '0, 0, 0, '0);
        chk("t6_spur_valid", 32'(inst_valid), 32'd1);
        chk("t6_spur_pc", 32'(inst_pc), 32'h101);
        cyc(0, 0, 0, '0, 1, 0, '0);
        cyc(0, 0, 0, '0, 0, 0, '0);
        chk("t6_drained", 32'(inst_valid), 32'd0);

        // Random interleavings
        do_reset();
        rnd_mode = 1;
        repeat (3000) cyc(0, 0, 0, '0, 0, 0, '0);
        rnd_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Parametrised successor to the single-shot instruction-memory read block.
- Autonomously fetches sequential instructions over the instruction bus into a DEPTH-entry prefetch queue.
- Hands each instruction and its PC to decode through a valid/ready handshake.
- Supports flush/redirect on branches and traps, and safely discards any in-flight response that the flush makes stale.

Parameters:
DEPTH, 4, queue entries; power of two, minimum 2
RESET_PC, 30'h0, word address [31:2] loaded into the fetch PC at reset
PTR_W, $clog2(DEPTH), queue pointer width (derived; do not override)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
fetch_en  in  1  permit new bus requests (CPU run state)
flush  in  1  redirect pulse; discards queue contents and any in-flight response
flush_pc  in  30  new fetch word address [31:2], sampled when flush=1
inst_valid  out  1  queue head holds a valid instruction
inst_ready  in  1  decode accepts head (inverse of stall)
inst  out  32  head instruction word
inst_pc  out  30  head instruction word address [31:2]
imr_run  out  1  request issued or response outstanding
i_read_req  out  1  bus request pulse, one cycle
i_read_w  out  1  constant 1 (bus read/word encoding)
i_read_hw  out  1  constant 0
i_read_adr  out  32  {fetch_pc, 2'b00}
i_read_valid  in  1  response strobe, one cycle
i_read_data  in  32  response data, valid with i_read_valid

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Every state element is updated only on a clk rising edge where rst is sampled.
- Values on reset:
  - state=IDLE, fetch_pc=RESET_PC, queue count=0, pointers=0.
  - inst_valid=0, inst=0, inst_pc=0, i_read_req=0, imr_run=0.
- FSM has three states:
  - IDLE: no outstanding request.
  - WAIT: request outstanding; the response will be kept.
  - DROP: request outstanding; the response will be discarded.
- Request issue:
  - i_read_req = (state==IDLE) & fetch_en & ~flush & (count<DEPTH). It is combinational and asserts for one cycle only.
  - On an issue cycle: state becomes WAIT and fetch_pc is incremented by 1 (word), wrapping modulo 2^30.
  - i_read_adr always presents the current fetch_pc.
- At most one outstanding request at any time. Because requests issue only from IDLE, the queue slot for the response is always reserved.
- WAIT, i_read_valid=1, flush=0:
  - Push {fetch_pc_of_request, i_read_data} into the queue; the stored PC is the fetch_pc value before the increment.
  - State becomes IDLE.
  - The next request may issue in the following cycle. Peak throughput is 1 instruction per 2 cycles with a 1-cycle bus.
- DROP, i_read_valid=1: no push; state becomes IDLE.
- i_read_valid while in IDLE is ignored. No push, no error.
- Queue output timing: data is pushed at edge N and inst_valid=1 from cycle N+1. inst and inst_pc are the registered head, stable while inst_valid & ~inst_ready.
- Pop occurs when inst_valid & inst_ready. A push and a pop in the same cycle leave count unchanged. A pop at count=1 together with a push gives a seamless head update.
- Full: at count==DEPTH no request is issued. The in-flight response always fits.
- Empty: inst_valid=0; inst_ready is ignored.
- Flush has highest priority. In the flush cycle:
  - Queue is cleared (count=0, pointers=0, inst_valid=0 next cycle).
  - fetch_pc is loaded from flush_pc.
  - No request is issued.
  - State: WAIT becomes DROP. If i_read_valid coincides with the flush while in WAIT, the data is dropped and the state becomes IDLE. IDLE stays IDLE. DROP stays DROP, or becomes IDLE if i_read_valid is also present.
- A pop coinciding with flush is discarded; the flush wins.
- Deasserting fetch_en does not abort an outstanding request. Its response is still pushed into the queue.
- imr_run = i_read_req | (state!=IDLE).
- Reset mid-transaction returns the block to IDLE. A bus response arriving after reset lands in IDLE and is ignored.

Decomposition:
- Shared package (cpu_fetch_pkg):
  - FSM state localparams IDLE=2'd0, WAIT=2'd1, DROP=2'd2.
  - INST_W=32 and PC_W=30 constants.
  - NOP encoding 32'h00000013, for consumers needing a bubble value.
- One natural sub-module, fetch_fifo:
  - Synchronous DEPTH×(PC_W+INST_W) FIFO with push, pop, clear, count, and registered head output.
  - The top level holds the FSM, fetch_pc and bus glue.

Test Plan:
- Reset RESET_PC=30'h100, fetch_en=1, bus responds 1 cycle after each req, inst_ready=1 -> requests at adr 0x400, 0x404, 0x408. inst_pc sequence is 0x100, 0x101, 0x102 with matching data, and no duplicates.
- DEPTH=4, inst_ready=0 -> exactly 4 requests, then i_read_req stays 0. Raise inst_ready -> 4 entries drain in order and fetching resumes at adr 0x410.
- Request outstanding (WAIT), flush=1 with flush_pc=30'h200 -> no push. The next response (data 0xDEADBEEF) is dropped and never appears on inst. The next request goes to adr 0x800.
- flush and i_read_valid in the same cycle in WAIT -> data dropped, state IDLE next cycle, next req at {flush_pc,2'b00}, queue empty.
- Assert rst for one cycle while in WAIT and queue holds 2 entries -> inst_valid=0 and fetch_pc=RESET_PC next cycle. A late i_read_valid produces no push.
- Push and pop in the same cycle at count=1 -> count stays 1, inst updates to the new word with no inst_valid gap. A spurious i_read_valid in IDLE leaves count unchanged.
